md_sequencer: RTL

//  Iterative RV32M multiply/divide controller beside the EX-stage ALU.

---
 rtl/md_pkg.sv | 44 ++++
 rtl/md_addsub.sv | 21 ++
 rtl/md_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// funct3 op encodings, FSM state encoding and op-classification helpers.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } md_state_e;

   // Divide-family ops all have funct3[2] set.
   function automatic logic is_div(input md_op_e op);
      return op[2];
   endfunction

   // rs1 is treated as signed for MUL/MULH/MULHSU/DIV/REM.
   function automatic logic op_signed_a(input md_op_e op);
      case (op)
         MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: return 1'b1;
         default:                                    return 1'b0;
      endcase
   endfunction

   // rs2 is treated as signed for MUL/MULH/DIV/REM.
   function automatic logic op_signed_b(input md_op_e op);
      case (op)
         MD_MUL, MD_MULH, MD_DIV, MD_REM: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/md_addsub.sv
// WIDTH+1-bit adder/subtractor shared by the multiply accumulate and the
// restoring-divide trial subtract. carry=1 on subtract means a >= b.
module md_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   input  logic           sub,
   output logic [WIDTH:0] sum,
   output logic           carry
);

   logic [WIDTH:0] b_eff;

   // sub=1 computes a + ~b + 1 with the carry out kept explicit
   always_comb begin
      b_eff        = sub ? ~b : b;
      {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{(WIDTH+1){1'b0}}, sub};
   end

endmodule

// File: rtl/md_sequencer.sv
// Iterative RV32M multiply/divide controller. One shift-add or restoring
// divide step per cycle on a single shared adder; sign fix-up in FIX.
// hi_q doubles as the divide remainder and lo_q as the quotient/dividend.
module md_sequencer
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Flush,
   output logic             Stall,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

   md_state_e        state_q, state_d;
   md_op_e           op_q, op_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;

   md_op_e           op_in;
   logic             accept, sa_in, sb_in, div_zero, div_ovf;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   as_a, as_b, as_sum;
   logic             as_sub, as_carry;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] quot_fix, rem_fix, fix_res;

   md_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a     (as_a),
      .b     (as_b),
      .sub   (as_sub),
      .sum   (as_sum),
      .carry (as_carry)
   );

   // Request decode: operand magnitudes and the one-cycle special cases
   always_comb begin
      op_in    = md_op_e'(Op);
      accept   = (state_q == ST_IDLE) & Start & ~Flush;
      sa_in    = op_signed_a(op_in) & A[WIDTH-1];
      sb_in    = op_signed_b(op_in) & B[WIDTH-1];
      abs_a    = sa_in ? (~A + WIDTH'(1)) : A;
      abs_b    = sb_in ? (~B + WIDTH'(1)) : B;
      div_zero = is_div(op_in) & (B == '0);
      div_ovf  = ((op_in == MD_DIV) | (op_in == MD_REM)) & (A == MIN_V) & (B == '1);
   end

   // Shared adder steering: divide trial-subtracts the shifted remainder,
   // multiply accumulates the multiplicand when the multiplier LSB is set
   always_comb begin
      as_sub = is_div(op_q);
      if (is_div(op_q)) begin
         as_a = {hi_q, lo_q[WIDTH-1]};
         as_b = {1'b0, mcand_q};
      end else begin
         as_a = {1'b0, hi_q};
         as_b = lo_q[0] ? {1'b0, mcand_q} : '0;
      end
   end

   // Sign fix-up and output word selection used in FIX
   always_comb begin
      prod     = {hi_q, lo_q};
      prod_fix = (sign_a_q ^ sign_b_q) ? (~prod + (2*WIDTH)'(1)) : prod;
      quot_fix = (sign_a_q ^ sign_b_q) ? (~lo_q + WIDTH'(1)) : lo_q;
      rem_fix  = sign_a_q ? (~hi_q + WIDTH'(1)) : hi_q;
      case (op_q)
         MD_MUL:                        fix_res = prod_fix[WIDTH-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  fix_res = prod_fix[2*WIDTH-1:WIDTH];
         MD_DIV, MD_DIVU:               fix_res = quot_fix;
         default:                       fix_res = rem_fix;
      endcase
   end

   // FSM next state and datapath updates
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      count_d  = count_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mcand_d  = mcand_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d     = op_in;
               sign_a_d = sa_in;
               sign_b_d = sb_in;
               if (div_zero) begin
                  result_d = (op_in == MD_DIV || op_in == MD_DIVU) ? '1 : A;
                  state_d  = ST_DONE;
               end else if (div_ovf) begin
                  result_d = (op_in == MD_DIV) ? MIN_V : '0;
                  state_d  = ST_DONE;
               end else begin
                  hi_d    = '0;
                  lo_d    = is_div(op_in) ? abs_a : abs_b;
                  mcand_d = is_div(op_in) ? abs_b : abs_a;
                  count_d = '0;
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (Flush) begin
               state_d = ST_IDLE;
            end else begin
               if (is_div(op_q)) begin
                  hi_d = as_carry ? as_sum[WIDTH-1:0] : as_a[WIDTH-1:0];
                  lo_d = {lo_q[WIDTH-2:0], as_carry};
               end else begin
                  hi_d = as_sum[WIDTH:1];
                  lo_d = {as_sum[0], lo_q[WIDTH-1:1]};
               end
               count_d = count_q + CW'(1);
               if (count_q == CW'(WIDTH-1)) state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (Flush) begin
               state_d = ST_IDLE;
            end else begin
               result_d = fix_res;
               state_d  = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         op_q     <= MD_MUL;
         count_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         count_q  <= count_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mcand_q  <= mcand_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   // Stall is forced low while reset is asserted so every output clears at once
   assign Stall  = rst & (accept | (state_q == ST_CALC) | (state_q == ST_FIX));
   assign Busy   = busy_q;
   assign Done   = done_q;
   assign Result = result_q;

endmodule
